spi_master: RTL and testbench

Single-channel SPI master that performs one 16-bit full-duplex transfer per `start` request, MSB first, SPI mode 0 (CPOL=0, CPHA=0). It serves as the serial link to the ADC wing: the parent logic places a command word on `data_in`, pulses `start`, and collects the returned word on `data_out` when `new_data` pulses. All logic runs on one system clock, and `sck` is derived from that clock by a programmable divider.

---
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one 16-bit MSB-first full-duplex transfer per accepted start; done 33*CLK_DIV clocks after accept.
// No backpressure: start is only sampled while idle and is otherwise dropped; busy marks the transfer window.
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miso,
    output logic        mosi,
    output logic        sck,
    output logic        ss,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        busy,
    output logic        new_data
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SCK_HIGH = 3'd2,
        SCK_LOW  = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_bit, w_bit_nxt;
    logic [15:0]   r_tx_sr, w_tx_sr_nxt;
    logic [15:0]   r_rx_sr, w_rx_sr_nxt;
    logic [15:0]   r_data_out, w_data_out_nxt;
    logic          r_sck, w_sck_nxt;
    logic          r_ss, w_ss_nxt;
    logic          r_mosi, w_mosi_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_new_data, w_new_data_nxt;
    logic          w_phase_end;

    assign w_phase_end = (r_cnt == CNT_MAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_nxt      = r_bit;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_data_out_nxt = r_data_out;
        w_sck_nxt      = r_sck;
        w_ss_nxt       = r_ss;
        w_mosi_nxt     = r_mosi;
        w_busy_nxt     = r_busy;
        w_new_data_nxt = r_new_data;

        case (r_state)
            IDLE: begin
                w_new_data_nxt = 1'b0;
                if (start) begin
                    w_tx_sr_nxt = data_in;
                    w_mosi_nxt  = data_in[15];
                    w_ss_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_bit_nxt   = 4'd0;
                    w_state_nxt = SETUP;
                end
            end
            SETUP, SCK_LOW: begin
                if (w_phase_end) begin
                    w_sck_nxt   = 1'b1;
                    w_rx_sr_nxt = {r_rx_sr[14:0], miso};
                    w_state_nxt = SCK_HIGH;
                end
            end
            SCK_HIGH: begin
                if (w_phase_end) begin
                    w_sck_nxt = 1'b0;
                    if (r_bit == 4'd15) begin
                        w_state_nxt = HOLD;
                    end else begin
                        // tx_sr shifts so the bit to drive next is always at [14]
                        w_bit_nxt   = r_bit + 4'd1;
                        w_tx_sr_nxt = {r_tx_sr[14:0], 1'b0};
                        w_mosi_nxt  = r_tx_sr[14];
                        w_state_nxt = SCK_LOW;
                    end
                end
            end
            HOLD: begin
                if (w_phase_end) begin
                    w_ss_nxt       = 1'b1;
                    w_busy_nxt     = 1'b0;
                    w_mosi_nxt     = 1'b0;
                    w_data_out_nxt = r_rx_sr;
                    w_new_data_nxt = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // every phase end changes state, so the divider never needs an explicit wrap
        if (w_state_nxt != r_state || r_state == IDLE) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_tx_sr    <= 16'h0000;
            r_rx_sr    <= 16'h0000;
            r_data_out <= 16'h0000;
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_new_data <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_data_out <= w_data_out_nxt;
            r_sck      <= w_sck_nxt;
            r_ss       <= w_ss_nxt;
            r_mosi     <= w_mosi_nxt;
            r_busy     <= w_busy_nxt;
            r_new_data <= w_new_data_nxt;
        end
    end

    assign mosi     = r_mosi;
    assign sck      = r_sck;
    assign ss       = r_ss;
    assign busy     = r_busy;
    assign new_data = r_new_data;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master: each transfer is checked against timing and data derived
// directly from the mode-0 rules (rise k at (2k+1)*D, completion at 33*D, word = sent or driven bits).
module tb_spi_master;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miso;
    logic        mosi;
    logic        sck;
    logic        ss;
    logic        start = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        busy;
    logic        new_data;

    logic loop_en  = 1'b0;
    logic miso_drv = 1'b0;
    assign miso = loop_en ? mosi : miso_drv;

    int n_cmp = 0;
    int n_bad = 0;

    spi_master #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .miso     (miso),
        .mosi     (mosi),
        .sck      (sck),
        .ss       (ss),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .new_data (new_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer. lp: loopback (expected word = din), else miso follows pat MSB first.
    // mid_t: edge offset at which a spurious start is pulsed; abort_t: edge offset of a reset pulse;
    // hold: keep start high throughout so a new transfer re-triggers right after completion.
    task automatic xfer(input string nm, input logic [15:0] din, input logic lp,
                        input logic [15:0] pat, input int mid_t, input int abort_t,
                        input logic hold);
        int          rises, first_rise, last_rise, busy_cnt, ss_rise, nd_cnt;
        logic [15:0] mosi_w, got_out, exp_word;
        logic        prev_sck;
        int          tend;
        exp_word   = lp ? din : pat;
        rises      = 0;
        first_rise = -1;
        last_rise  = -1;
        ss_rise    = -1;
        nd_cnt     = 0;
        mosi_w     = 16'h0000;
        got_out    = 16'h0000;
        loop_en    = lp;
        miso_drv   = pat[15];
        data_in    = din;
        start      = 1'b1;
        @(negedge clk);
        chk({nm, ".busy_at_E0"}, {31'd0, busy}, 32'd1);
        chk({nm, ".ss_at_E0"}, {31'd0, ss}, 32'd0);
        chk({nm, ".mosi_at_E0"}, {31'd0, mosi}, {31'd0, din[15]});
        if (!hold) start = 1'b0;
        data_in  = 16'($urandom);
        busy_cnt = busy ? 1 : 0;
        prev_sck = sck;
        tend     = 33 * D + 3;
        for (int t = 1; t <= tend; t++) begin
            @(negedge clk);
            if (t == mid_t) begin
                start   = 1'b1;
                data_in = 16'hABCD;
            end
            if (t == mid_t + 1 && !hold) start = 1'b0;
            if (abort_t > 0 && t == abort_t) rst = 1'b0;
            if (abort_t > 0 && t == abort_t + 1) begin
                rst = 1'b1;
                chk({nm, ".abort_sck"}, {31'd0, sck}, 32'd0);
                chk({nm, ".abort_ss"}, {31'd0, ss}, 32'd1);
                chk({nm, ".abort_mosi"}, {31'd0, mosi}, 32'd0);
                chk({nm, ".abort_busy"}, {31'd0, busy}, 32'd0);
                chk({nm, ".abort_nd"}, {31'd0, new_data}, 32'd0);
                chk({nm, ".abort_dout"}, {16'd0, data_out}, 32'd0);
            end
            if (sck && !prev_sck) begin
                if (first_rise < 0) first_rise = t;
                last_rise = t;
                mosi_w    = {mosi_w[14:0], mosi};
                rises++;
                if (rises < 16) miso_drv = pat[15 - rises];
            end
            prev_sck = sck;
            if (busy && t <= 33 * D) busy_cnt++;
            if (ss && ss_rise < 0) ss_rise = t;
            if (new_data) begin
                nd_cnt++;
                got_out = data_out;
            end
            if (hold && t == 33 * D + 1) begin
                chk({nm, ".retrig_busy"}, {31'd0, busy}, 32'd1);
                chk({nm, ".retrig_ss"}, {31'd0, ss}, 32'd0);
                start = 1'b0;
            end
        end
        if (abort_t > 0) begin
            chk({nm, ".abort_no_nd"}, nd_cnt, 32'd0);
        end else begin
            chk({nm, ".rises"}, rises, 32'd16);
            chk({nm, ".first_rise"}, first_rise, D);
            chk({nm, ".last_rise"}, last_rise, 31 * D);
            chk({nm, ".ss_rise"}, ss_rise, 33 * D);
            chk({nm, ".busy_len"}, busy_cnt, 33 * D);
            chk({nm, ".nd_pulses"}, nd_cnt, 32'd1);
            chk({nm, ".nd_word"}, {16'd0, got_out}, {16'd0, exp_word});
            chk({nm, ".dout_hold"}, {16'd0, data_out}, {16'd0, exp_word});
            if (lp) chk({nm, ".mosi_word"}, {16'd0, mosi_w}, {16'd0, din});
        end
        if (hold) repeat (33 * D + 5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.sck", {31'd0, sck}, 32'd0);
        chk("rst.ss", {31'd0, ss}, 32'd1);
        chk("rst.mosi", {31'd0, mosi}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.nd", {31'd0, new_data}, 32'd0);
        chk("rst.dout", {16'd0, data_out}, 32'd0);

        xfer("loop1234", 16'h1234, 1'b1, 16'h0000, 0, 0, 1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        xfer("miso0", 16'($urandom), 1'b0, 16'h0000, 0, 0, 1'b0);
        xfer("miso1", 16'($urandom), 1'b0, 16'hFFFF, 0, 0, 1'b0);
        xfer("midstart", 16'h1234, 1'b1, 16'h0000, 50, 0, 1'b0);
        xfer("abort", 16'hFFFF, 1'b1, 16'h0000, 0, 62, 1'b0);
        xfer("after_abort", 16'h5A5A, 1'b1, 16'h0000, 0, 0, 1'b0);
        xfer("hold", 16'($urandom), 1'b1, 16'h0000, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer($sformatf("rnd%0d", i), 16'($urandom), 1'($urandom_range(0, 1)),
                 16'($urandom), 0, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
